// File: rtl/pulse_to_level.sv
// pulse_to_level
//   Turns single-cycle trigger/cancel strobes into a level. The level can be
//   held until it is cancelled (latched mode), or it can be held for a
//   programmed number of cycles (timed mode).
//
// Ports
//   clk          system clock; all state changes happen on its rising edge
//   rst          asynchronous active-high reset
//   p_in         trigger strobe
//   n_in         cancel strobe; it always wins over p_in in the same cycle
//   mode         0 = latched set/clear, 1 = timed hold (sampled on an accepted trigger)
//   hold_cycles  timed-mode high duration in cycles (sampled on an accepted trigger)
//   level        registered generated level, high in LATCHED and TIMED
//   busy         high whenever the FSM is not IDLE
//   expired      one-cycle pulse in the first low cycle after a natural timed end
//   remaining    high cycles left after the current one while TIMED, else 0
//   dbg_state    current FSM state (0 IDLE, 1 LATCHED, 2 TIMED)
//
// Configuration
//   PULSE_TO_LEVEL_RETRIGGER_EN  when defined, a trigger during TIMED reloads
//                                the counter from hold_cycles-1. A hold_cycles
//                                value of 0 is not reloaded. When the macro is
//                                undefined, a trigger during TIMED is ignored.
//
// Handshake: p_in and n_in are fire-and-forget strobes. They have no ready
// and no backpressure. Each cycle in which a strobe is high counts as one
// event, and n_in dominates p_in in every state.
module pulse_to_level #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p_in,
  input  logic             n_in,
  input  logic             mode,
  input  logic [CNT_W-1:0] hold_cycles,
  output logic             level,
  output logic             busy,
  output logic             expired,
  output logic [CNT_W-1:0] remaining,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LATCHED = 2'd1,
    TIMED   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q;
  logic             expired_q, expired_d;
  logic             trig;
  logic             retrig_ok;

  // A trigger counts only when no cancel is present in the same cycle.
  assign trig = p_in & ~n_in;

`ifdef PULSE_TO_LEVEL_RETRIGGER_EN
  assign retrig_ok = trig & (hold_cycles != '0);
`else
  assign retrig_ok = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      // The level is registered from the next state so that it stays glitch-free.
      level_q   <= (state_d != IDLE);
      expired_q <= expired_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    expired_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (trig) begin
          if (!mode) begin
            state_d = LATCHED;
          end else if (hold_cycles != '0) begin
            // The counter holds the cycles left after the current one,
            // so an N-cycle hold starts at N-1.
            state_d = TIMED;
            cnt_d   = hold_cycles - ONE;
          end
        end
      end
      LATCHED: begin
        if (n_in) state_d = IDLE;
      end
      TIMED: begin
        if (n_in) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (retrig_ok) begin
          cnt_d = hold_cycles - ONE;
        end else if (cnt_q == '0) begin
          state_d   = IDLE;
          expired_d = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    level     = level_q;
    busy      = (state_q != IDLE);
    expired   = expired_q;
    remaining = (state_q == TIMED) ? cnt_q : '0;
    dbg_state = state_q;
  end

endmodule

// File: doc/pulse_to_level.md
PULSE_TO_LEVEL -- requirements
Module: pulse_to_level

Interface
REQ-001 Parameter: CNT_W, 16, width of hold_cycles and remaining.
REQ-002 Port: clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: p_in  input  1  trigger pulse (one-cycle pulse from an edge detector).
REQ-005 Port: n_in  input  1  cancel/clear pulse.
REQ-006 Port: mode  input  1  0 = latched set/clear, 1 = timed hold; sampled only on an accepted trigger.
REQ-007 Port: hold_cycles  input  CNT_W  timed-mode high duration in clk cycles; sampled only on an accepted trigger.
REQ-008 Port: level  output  1  registered generated level.
REQ-009 Port: busy  output  1  high whenever state is not IDLE.
REQ-010 Port: expired  output  1  one-cycle pulse on natural end of a timed hold.
REQ-011 Port: remaining  output  CNT_W  cycles of high level left after the current cycle in TIMED; 0 otherwise.

Function
REQ-012 The block SHALL implement three states: IDLE, LATCHED, TIMED; level SHALL be 1 exactly in LATCHED and TIMED.
REQ-013 IDLE: p_in=1, n_in=0, mode=0 SHALL go to LATCHED; level rises the cycle after the trigger edge.
REQ-014 IDLE: p_in=1, n_in=0, mode=1, hold_cycles=N>0 SHALL go to TIMED with counter=N-1; level high for exactly N cycles.
REQ-015 IDLE: trigger with mode=1 and hold_cycles=0 SHALL be ignored (stay IDLE, no level, no expired).
REQ-016 p_in and n_in in the same cycle: n_in SHALL win in every state.
REQ-017 LATCHED: n_in SHALL go to IDLE (level low next cycle); p_in, mode, hold_cycles ignored.
REQ-018 TIMED: counter decrements each cycle; at counter=0 with no retrigger, next state IDLE.
REQ-019 expired SHALL be 1 for exactly one cycle, the first cycle level is 0 after a natural TIMED end.
REQ-020 TIMED: n_in SHALL go to IDLE next cycle, counter cleared, expired not asserted.
REQ-021 remaining SHALL equal the counter in TIMED, 0 in IDLE and LATCHED.
REQ-022 Input changes to mode/hold_cycles outside an accepted trigger SHALL have no effect.

Reset
REQ-023 rst=1 SHALL immediately force state IDLE, counter 0, level 0, busy 0, expired 0, remaining 0, regardless of clk.
REQ-024 Reset asserted mid-hold SHALL abort without expired; first trigger after deassertion behaves as from IDLE.

Configuration
REQ-025 Macro PULSE_TO_LEVEL_RETRIGGER_EN defined: p_in (n_in=0) in TIMED SHALL reload counter from current hold_cycles-1 (hold_cycles=0 reload ignored), level stays high, no expired; applies also when counter=0.
REQ-026 Macro undefined: p_in in TIMED SHALL be ignored; hold ends on original schedule.

Verification
REQ-027 mode=0, p_in at cycle 10, n_in at cycle 20 -> level=1 cycles 11-20, 0 from 21; busy matches; expired never.
REQ-028 mode=1, hold_cycles=5, p_in at cycle 10 -> level=1 cycles 11-15, remaining 4,3,2,1,0, expired=1 at cycle 16 only.
REQ-029 mode=1, hold_cycles=5, p_in at 10, p_in again at 13 -> with RETRIGGER_EN level high 11-18, expired at 19; without, level high 11-15, expired at 16.
REQ-030 p_in and n_in together at cycle 10 from IDLE -> level stays 0; mode=1, hold_cycles=0 trigger -> no level, no expired.
REQ-031 mode=1, hold_cycles=8, p_in at 10, rst pulse mid-cycle 13 -> level, busy, remaining drop to 0 asynchronously; expired never asserted.
REQ-032 mode=1, hold_cycles=65535 -> level high exactly 65535 cycles, remaining starts at 65534, no wrap.
